data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Responder end of the CPU data-memory interface (`mem_ren`/`mem_wen`/`mem_addr`/`mem_dout`/`mem_din`).
- Owns a word-addressed synchronous RAM and serves the MEM-stage request with a configurable access latency.
- Drives `mem_stall` to the pipeline controller, which holds the MEM stage and everything upstream.
- Read data is held stable for the WB-stage capture edge.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth 2**ADDR_WIDTH words of 32 bits.
- LATENCY, 2, stall cycles per access; legal range 1..15.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_ren  in  1  read request from CPU MEM stage.
- mem_wen  in  1  write request from CPU MEM stage.
- mem_addr  in  32  byte address; bits [ADDR_WIDTH+1:2] index the array.
- mem_dout  in  32  write data from CPU.
- mem_din  out  32  read data to CPU.
- mem_stall  out  1  hold request; CPU keeps all request signals constant while high.
- mem_err  out  1  last completed access was misaligned.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - mem_din=0, mem_stall=0, mem_err=0.
  - Array contents are not cleared.
- FSM states IDLE, WAIT, DONE; encoding 2 bits.
- Request present = mem_ren | mem_wen.
- IDLE:
  - No request: stay in IDLE, mem_stall=0.
  - Request present: mem_stall=1 combinationally in the same cycle and the counter loads LATENCY-1.
  - Next state is DONE if LATENCY==1, else WAIT.
- WAIT:
  - mem_stall=1 and the counter decrements.
  - When the counter reaches 0, go to DONE.
- DONE:
  - mem_stall=0 and the access commits at the rising edge ending DONE.
  - Next state is always IDLE.
  - A request seen in the following IDLE cycle is a new access, including same-address back-to-back.
- Total stall: exactly LATENCY cycles per access. The CPU advances on the DONE edge.
- Write: array[idx] <= mem_dout on the DONE edge.
- Read: mem_din is registered on the DONE edge and held until the next completed read.
  - The WB capture edge (the edge after DONE) sees the new data.
  - The array read port is synchronous; its address is presented during the last WAIT/IDLE cycle.
- ren & wen both high: treated as a read-modify access.
  - mem_din returns the pre-write contents.
  - The write also commits.
- Misaligned address (mem_addr[1:0]!=0):
  - Full latency is still applied.
  - No write is committed and mem_din is unchanged.
  - mem_err=1 is registered on the DONE edge.
  - mem_err clears on the next aligned completion.
- Out-of-range high address bits are ignored; the address wraps modulo the array depth.
- Request withdrawn (ren=wen=0) during WAIT, i.e. a pipeline flush: abort to IDLE next cycle, mem_stall=0, no commit.
- Reset asserted mid-access: the access is dropped and no write is committed.
- A change of mem_addr/mem_dout while stalled is a protocol violation. Behaviour is undefined; flag it with an assertion in simulation only.

Optional Feature:
- Macro DMEM_STATS_EN.
- Defined:
  - Adds outputs stat_reads[31:0], stat_writes[31:0] and stat_stalls[31:0].
  - stat_reads and stat_writes count committed accesses; misaligned and aborted accesses are excluded.
  - stat_stalls counts cycles with mem_stall=1.
  - All counters reset to 0 and wrap at 2**32.
- Undefined: the ports and logic are absent. Core behaviour is identical.

Decomposition:
- Shared header mips_mem_define.vh holds:
  - FSM state constants DMEM_IDLE=0, DMEM_WAIT=1, DMEM_DONE=2.
  - Latency bounds DMEM_LAT_MIN=1, DMEM_LAT_MAX=15.
  - The counter width of 4.
- One sub-module, dmem_array: single-port synchronous 32-bit RAM with parameter ADDR_WIDTH and ports clk, en, we, addr, din, dout.
  - dout is valid the cycle after en.

Test Plan:
- LATENCY=2, write 0xDEADBEEF to 0x40, then read 0x40 → mem_stall high 2 cycles each; mem_din=0xDEADBEEF after the read's DONE edge; mem_err=0.
- LATENCY=1, back-to-back reads of 0x0 then 0x4 (preloaded 0x11111111, 0x22222222) → one stall cycle each; mem_din sequence 0x11111111, 0x22222222.
- Write 0x12345678 to 0x43 (misaligned) → 2 stall cycles; mem_err=1; a subsequent aligned read of 0x40 returns the old value; mem_err=0 after it.
- Address wrap, ADDR_WIDTH=10: write 0xA5A5A5A5 to 0x1000 → a read of 0x0 returns 0xA5A5A5A5.
- Abort and reset:
  - Start a write to 0x80 with LATENCY=4, drop wen in the 2nd stall cycle → IDLE, mem_stall=0, 0x80 unchanged.
  - Repeat with rst_n pulsed low mid-WAIT → outputs 0 immediately, no commit.
- With DMEM_STATS_EN: 3 reads + 2 writes + 1 misaligned write at LATENCY=2 → stat_reads=3, stat_writes=2, stat_stalls=12.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
package data_mem_resp_pkg;

   localparam int unsigned DMEM_LAT_MIN = 1;
   localparam int unsigned DMEM_LAT_MAX = 15;
   localparam int unsigned DMEM_CNT_W   = 4;
   localparam int unsigned DMEM_DATA_W  = 32;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_DONE = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, read-first; dout is valid the cycle after en.
module dmem_array
   import data_mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   en,
   input  logic                   we,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [DMEM_DATA_W-1:0] din,
   output logic [DMEM_DATA_W-1:0] dout
);

   logic [DMEM_DATA_W-1:0] mem_q [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= din;
         end
         dout <= mem_q[addr];
      end
   end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: stalls the CPU MEM stage for LATENCY cycles per access.
// Define DMEM_STATS_EN to add read/write/stall statistics counters.
module data_mem_resp
   import data_mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        mem_stall,
   output logic        mem_err
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0] stat_reads,
   output logic [31:0] stat_writes,
   output logic [31:0] stat_stalls
`endif
);

   if (LATENCY < DMEM_LAT_MIN || LATENCY > DMEM_LAT_MAX) begin : g_bad_latency
      $error("data_mem_resp: LATENCY out of range 1..15");
   end

   localparam logic [DMEM_CNT_W-1:0] LAT_M1  = DMEM_CNT_W'(LATENCY - 1);
   localparam logic [DMEM_CNT_W-1:0] CNT_ONE = DMEM_CNT_W'(1);

   dmem_state_e             state_q, state_d;
   logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]             din_q, din_d;
   logic                    err_q, err_d;
   logic                    stall;
   logic                    ram_rd, ram_wr;
   logic [31:0]             ram_dout;
   logic                    req, aligned;
   logic [ADDR_WIDTH-1:0]   idx;
   logic                    unused_addr_hi;

   assign req            = mem_ren | mem_wen;
   assign aligned        = (mem_addr[1:0] == 2'b00);
   assign idx            = mem_addr[ADDR_WIDTH+1:2];
   assign unused_addr_hi = ^mem_addr[31:ADDR_WIDTH+2];

   // The RAM read is issued on the cycle before DONE so its data is ready in DONE;
   // the write lands on the edge ending DONE, so a read-modify returns pre-write data.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      err_d   = err_q;
      stall   = 1'b0;
      ram_rd  = 1'b0;
      ram_wr  = 1'b0;
      unique case (state_q)
         DMEM_IDLE: begin
            if (req) begin
               stall = 1'b1;
               cnt_d = LAT_M1;
               if (LATENCY == 1) begin
                  state_d = DMEM_DONE;
                  ram_rd  = mem_ren;
               end else begin
                  state_d = DMEM_WAIT;
               end
            end
         end
         DMEM_WAIT: begin
            if (!req) begin
               state_d = DMEM_IDLE;
               cnt_d   = '0;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = DMEM_DONE;
                  ram_rd  = mem_ren;
               end
            end
         end
         DMEM_DONE: begin
            state_d = DMEM_IDLE;
            if (req) begin
               err_d = ~aligned;
               if (aligned) begin
                  ram_wr = mem_wen;
                  if (mem_ren) begin
                     din_d = ram_dout;
                  end
               end
            end
         end
         default: state_d = DMEM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DMEM_IDLE;
         cnt_q   <= '0;
         din_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         err_q   <= err_d;
      end
   end

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk  (clk),
      .en   (ram_rd | ram_wr),
      .we   (ram_wr),
      .addr (idx),
      .din  (mem_dout),
      .dout (ram_dout)
   );

   // Stall is combinational from the request, so force it low while reset is held.
   assign mem_stall = stall & rst_n;
   assign mem_din   = din_q;
   assign mem_err   = err_q;

`ifdef DMEM_STATS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic [31:0] st_cnt_q, st_cnt_d;
   logic        commit;

   assign commit = (state_q == DMEM_DONE) && req && aligned;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      st_cnt_d = st_cnt_q;
      if (commit && mem_ren) rd_cnt_d = rd_cnt_q + 32'd1;
      if (commit && mem_wen) wr_cnt_d = wr_cnt_q + 32'd1;
      if (mem_stall)         st_cnt_d = st_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         st_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         st_cnt_q <= st_cnt_d;
      end
   end

   assign stat_reads  = rd_cnt_q;
   assign stat_writes = wr_cnt_q;
   assign stat_stalls = st_cnt_q;
`endif

`ifndef SYNTHESIS
   a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      ((state_q != DMEM_IDLE) && req) |-> ($stable(mem_addr) && $stable(mem_dout)))
      else $error("data_mem_resp: request address/data changed while stalled");
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp at LATENCY 2, 1 and 4 (instances 0, 1, 2).
module tb_data_mem_resp;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        ren  [3];
   logic        wen  [3];
   logic [31:0] addr [3];
   logic [31:0] dout [3];
   logic [31:0] din  [3];
   logic        stall[3];
   logic        err  [3];
`ifdef DMEM_STATS_EN
   logic [31:0] s_rd[3];
   logic [31:0] s_wr[3];
   logic [31:0] s_st[3];
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_resp #(.ADDR_WIDTH(10), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .mem_ren(ren[0]), .mem_wen(wen[0]),
      .mem_addr(addr[0]), .mem_dout(dout[0]), .mem_din(din[0]),
      .mem_stall(stall[0]), .mem_err(err[0])
`ifdef DMEM_STATS_EN
      , .stat_reads(s_rd[0]), .stat_writes(s_wr[0]), .stat_stalls(s_st[0])
`endif
   );

   data_mem_resp #(.ADDR_WIDTH(10), .LATENCY(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .mem_ren(ren[1]), .mem_wen(wen[1]),
      .mem_addr(addr[1]), .mem_dout(dout[1]), .mem_din(din[1]),
      .mem_stall(stall[1]), .mem_err(err[1])
`ifdef DMEM_STATS_EN
      , .stat_reads(s_rd[1]), .stat_writes(s_wr[1]), .stat_stalls(s_st[1])
`endif
   );

   data_mem_resp #(.ADDR_WIDTH(10), .LATENCY(4)) u_lat4 (
      .clk(clk), .rst_n(rst_n), .mem_ren(ren[2]), .mem_wen(wen[2]),
      .mem_addr(addr[2]), .mem_dout(dout[2]), .mem_din(din[2]),
      .mem_stall(stall[2]), .mem_err(err[2])
`ifdef DMEM_STATS_EN
      , .stat_reads(s_rd[2]), .stat_writes(s_wr[2]), .stat_stalls(s_st[2])
`endif
   );

   // Called just after a rising edge; returns just after the DONE edge.
   task automatic do_access(input int s, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            output int nstall);
      ren[s] = r; wen[s] = w; addr[s] = a; dout[s] = d;
      nstall = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (stall[s]) nstall++;
         else break;
      end
      @(posedge clk); #1;
   endtask

   task automatic go_idle(input int s);
      ren[s] = 1'b0; wen[s] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) begin
         checks++; if (din[i] !== 32'h0) begin errors++; $display("FAIL reset_din[%0d]: got %h expected 00000000", i, din[i]); end
         checks++; if (stall[i] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d]: got %b expected 0", i, stall[i]); end
         checks++; if (err[i] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", i, err[i]); end
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      int n;
      do_access(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL wr_stall: got %0d expected 2", n); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", err[0]); end
      go_idle(0);
      do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL rd_stall: got %0d expected 2", n); end
      checks++; if (din[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", din[0]); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", err[0]); end
      go_idle(0);
   endtask

   task automatic test_back_to_back();
      int n;
      do_access(1, 1'b0, 1'b1, 32'h0, 32'h11111111, n);
      do_access(1, 1'b0, 1'b1, 32'h4, 32'h22222222, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL b2b_wr_stall: got %0d expected 1", n); end
      do_access(1, 1'b1, 1'b0, 32'h0, 32'h0, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL b2b_rd0_stall: got %0d expected 1", n); end
      checks++; if (din[1] !== 32'h11111111) begin errors++; $display("FAIL b2b_rd0_data: got %h expected 11111111", din[1]); end
      do_access(1, 1'b1, 1'b0, 32'h4, 32'h0, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL b2b_rd1_stall: got %0d expected 1", n); end
      checks++; if (din[1] !== 32'h22222222) begin errors++; $display("FAIL b2b_rd1_data: got %h expected 22222222", din[1]); end
      do_access(1, 1'b1, 1'b0, 32'h4, 32'h0, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL b2b_same_addr_stall: got %0d expected 1", n); end
      go_idle(1);
   endtask

   task automatic test_read_modify();
      int n;
      do_access(0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL rmw_stall: got %0d expected 2", n); end
      checks++; if (din[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rmw_old_data: got %h expected deadbeef", din[0]); end
      go_idle(0);
      do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, n);
      checks++; if (din[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL rmw_new_data: got %h expected cafef00d", din[0]); end
      go_idle(0);
   endtask

   task automatic test_misaligned();
      int n;
      do_access(0, 1'b0, 1'b1, 32'h44, 32'h0BADF00D, n);
      do_access(0, 1'b0, 1'b1, 32'h43, 32'h12345678, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL mis_wr_stall: got %0d expected 2", n); end
      checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL mis_wr_err: got %b expected 1", err[0]); end
      checks++; if (din[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_wr_din_held: got %h expected cafef00d", din[0]); end
      do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, n);
      checks++; if (din[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_no_commit: got %h expected cafef00d", din[0]); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL mis_err_clear: got %b expected 0", err[0]); end
      do_access(0, 1'b1, 1'b0, 32'h46, 32'h0, n);
      checks++; if (din[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_rd_din_held: got %h expected cafef00d", din[0]); end
      checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL mis_rd_err: got %b expected 1", err[0]); end
      do_access(0, 1'b1, 1'b0, 32'h44, 32'h0, n);
      checks++; if (din[0] !== 32'h0BADF00D) begin errors++; $display("FAIL mis_rd_aligned: got %h expected 0badf00d", din[0]); end
      go_idle(0);
   endtask

   task automatic test_wrap();
      int n;
      do_access(0, 1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, n);
      go_idle(0);
      do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, n);
      checks++; if (din[0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_data: got %h expected a5a5a5a5", din[0]); end
      go_idle(0);
   endtask

   task automatic test_abort();
      int n;
      do_access(2, 1'b0, 1'b1, 32'h80, 32'h55AA55AA, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL lat4_stall: got %0d expected 4", n); end
      go_idle(2);
      ren[2] = 1'b0; wen[2] = 1'b1; addr[2] = 32'h80; dout[2] = 32'hBADBAD00;
      @(negedge clk);
      checks++; if (stall[2] !== 1'b1) begin errors++; $display("FAIL abort_first_stall: got %b expected 1", stall[2]); end
      @(posedge clk); #1;
      wen[2] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (stall[2] !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b expected 0", stall[2]); end
      @(posedge clk); #1;
      do_access(2, 1'b1, 1'b0, 32'h80, 32'h0, n);
      checks++; if (din[2] !== 32'h55AA55AA) begin errors++; $display("FAIL abort_no_commit: got %h expected 55aa55aa", din[2]); end
      go_idle(2);
   endtask

   task automatic test_reset_mid();
      int n;
      ren[2] = 1'b0; wen[2] = 1'b1; addr[2] = 32'h80; dout[2] = 32'hBADBAD01;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if (din[2] !== 32'h0) begin errors++; $display("FAIL rstmid_din: got %h expected 00000000", din[2]); end
      checks++; if (stall[2] !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", stall[2]); end
      checks++; if (err[2] !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", err[2]); end
      wen[2] = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      do_access(2, 1'b1, 1'b0, 32'h80, 32'h0, n);
      checks++; if (din[2] !== 32'h55AA55AA) begin errors++; $display("FAIL rstmid_no_commit: got %h expected 55aa55aa", din[2]); end
      go_idle(2);
   endtask

`ifdef DMEM_STATS_EN
   task automatic test_stats();
      int n;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (s_st[0] !== 32'd0) begin errors++; $display("FAIL stat_reset: got %0d expected 0", s_st[0]); end
      do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, n);
      do_access(0, 1'b0, 1'b1, 32'h48, 32'h1, n);
      do_access(0, 1'b1, 1'b0, 32'h44, 32'h0, n);
      do_access(0, 1'b0, 1'b1, 32'h49, 32'h2, n);
      do_access(0, 1'b0, 1'b1, 32'h4C, 32'h3, n);
      do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, n);
      go_idle(0);
      checks++; if (s_rd[0] !== 32'd3) begin errors++; $display("FAIL stat_reads: got %0d expected 3", s_rd[0]); end
      checks++; if (s_wr[0] !== 32'd2) begin errors++; $display("FAIL stat_writes: got %0d expected 2", s_wr[0]); end
      checks++; if (s_st[0] !== 32'd12) begin errors++; $display("FAIL stat_stalls: got %0d expected 12", s_st[0]); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 3; i++) begin
         ren[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; dout[i] = '0;
      end
      test_reset();
      test_write_read();
      test_back_to_back();
      test_read_modify();
      test_misaligned();
      test_wrap();
      test_abort();
      test_reset_mid();
`ifdef DMEM_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
